// File: rtl/mram_weight_loader.sv
// mram_weight_loader: packs the MRAM read-path byte stream (one byte per
// falling edge of clk_fifo) into WORD_BYTES-wide words and writes them into
// the weight buffer. Keeps a byte count, a 16-bit running checksum and a
// watchdog that aborts a stalled load. Everything runs in the CLK domain;
// clk_fifo is oversampled through a synchroniser.
module mram_weight_loader #(
    parameter int NUM_BYTES   = 1800,
    parameter int WORD_BYTES  = 2,
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    CLK,
    input  logic                    Rst,
    input  logic                    start,
    input  logic                    clk_fifo,
    input  logic [7:0]              byte_in,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout_err,
    output logic [15:0]             byte_cnt,
    output logic [15:0]             checksum
);

    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [15:0]       NUM_CNT   = 16'(NUM_BYTES);
    localparam logic [15:0]       LAST_CNT  = 16'(NUM_BYTES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Drop byte b into lane 'lane' of word, leaving the other lanes unchanged.
    function automatic logic [WORD_W-1:0] insert_lane(
        input logic [WORD_W-1:0] word,
        input logic [LANE_W-1:0] lane,
        input logic [7:0]        b
    );
        logic [WORD_W-1:0] res;
        res = word;
        for (int k = 0; k < WORD_BYTES; k++) begin
            res[8*k +: 8] = (lane == LANE_W'(k)) ? b : res[8*k +: 8];
        end
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_next;
    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    sync_prev_r;
    logic                    strb_s;
    logic [WORD_W-1:0]       pack_r;
    logic [WORD_W-1:0]       packed_s;
    logic [LANE_W-1:0]       lane_r;
    logic [ADDR_W-1:0]       word_addr_r;
    logic [WD_W-1:0]         wd_r;
    logic                    accept_s;
    logic                    fire_s;
    logic                    clear_s;
    logic                    tick_s;
    logic                    expire_s;

    // A byte is announced by a falling edge of the synchronised clk_fifo.
    assign strb_s   = sync_prev_r & ~sync_r[SYNC_STAGES-1];
    assign packed_s = insert_lane(pack_r, lane_r, byte_in);

    // Synchroniser chain plus one edge-detect flop on clk_fifo.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            sync_r      <= '0;
            sync_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], clk_fifo};
            sync_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state_r;
        accept_s   = 1'b0;
        fire_s     = 1'b0;
        clear_s    = 1'b0;
        tick_s     = 1'b0;
        expire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clear_s    = 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (byte_cnt == NUM_CNT) begin
                    // Final full word was written last cycle.
                    state_next = ST_DONE;
                end else if (strb_s) begin
                    accept_s = 1'b1;
                    fire_s   = (lane_r == LAST_LANE) || (byte_cnt == LAST_CNT);
                    if ((byte_cnt == LAST_CNT) && (lane_r != LAST_LANE)) begin
                        state_next = ST_FLUSH;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end else if (wd_r == WD_LAST) begin
                    expire_s   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tick_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The zero-padded partial word is on the bus this cycle.
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    clear_s    = 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Packing, counters, watchdog and registered outputs.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            byte_cnt    <= 16'd0;
            checksum    <= 16'd0;
            pack_r      <= '0;
            lane_r      <= '0;
            word_addr_r <= '0;
            wd_r        <= '0;
        end else begin
            wr_en <= fire_s;
            busy  <= (state_next == ST_LOAD) || (state_next == ST_FLUSH);
            done  <= (state_next == ST_DONE);
            if (clear_s) begin
                timeout_err <= 1'b0;
                byte_cnt    <= 16'd0;
                checksum    <= 16'd0;
                pack_r      <= '0;
                lane_r      <= '0;
                word_addr_r <= '0;
                wd_r        <= '0;
            end else if (accept_s) begin
                byte_cnt <= byte_cnt + 16'd1;
                checksum <= checksum + {8'd0, byte_in};
                wd_r     <= '0;
                if (fire_s) begin
                    // Unfilled lanes are already zero because pack_r is
                    // cleared after every word.
                    wr_data     <= packed_s;
                    wr_addr     <= word_addr_r;
                    word_addr_r <= word_addr_r + ADDR_W'(1);
                    pack_r      <= '0;
                    lane_r      <= '0;
                end else begin
                    pack_r <= packed_s;
                    lane_r <= lane_r + LANE_W'(1);
                end
            end else if (expire_s) begin
                // Abort: drop the partial word, keep counters for diagnosis.
                timeout_err <= 1'b1;
                pack_r      <= '0;
                lane_r      <= '0;
                wd_r        <= '0;
            end else if (tick_s) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= wd_r;
            end
        end
    end

endmodule

// File: tb/tb_mram_weight_loader.sv
// Testbench for mram_weight_loader. Two instances share the stimulus:
// dut0 (WORD_BYTES=2, NUM_BYTES=301) ends every load with a FLUSH,
// dut1 (WORD_BYTES=3, NUM_BYTES=300) ends with a full final word.
// Expected writes and sums come from a byte-list model of the load.
module tb_mram_weight_loader;

    localparam int N0  = 301;
    localparam int W0  = 2;
    localparam int N1  = 300;
    localparam int W1  = 3;
    localparam int TMO = 64;

    typedef logic [41:0] ent_t;

    logic        CLK = 1'b0;
    logic        Rst;
    logic        start;
    logic        clk_fifo;
    logic [7:0]  byte_in;

    logic        wr_en0, wr_en1, busy0, busy1, done0, done1, tmo0, tmo1;
    logic [9:0]  wr_addr0, wr_addr1;
    logic [15:0] wr_data0;
    logic [23:0] wr_data1;
    logic [15:0] cnt0, cnt1, cks0, cks1;

    logic [1:0]  wr_en_v, busy_v, done_v, tmo_v;
    logic [9:0]  wr_addr_v [2];
    logic [31:0] wr_data_v [2];
    logic [15:0] cnt_v [2];
    logic [15:0] cks_v [2];

    assign wr_en_v      = {wr_en1, wr_en0};
    assign busy_v       = {busy1, busy0};
    assign done_v       = {done1, done0};
    assign tmo_v        = {tmo1, tmo0};
    assign wr_addr_v[0] = wr_addr0;
    assign wr_addr_v[1] = wr_addr1;
    assign wr_data_v[0] = {16'd0, wr_data0};
    assign wr_data_v[1] = {8'd0, wr_data1};
    assign cnt_v[0]     = cnt0;
    assign cnt_v[1]     = cnt1;
    assign cks_v[0]     = cks0;
    assign cks_v[1]     = cks1;

    mram_weight_loader #(.NUM_BYTES(N0), .WORD_BYTES(W0), .ADDR_W(10),
                         .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut0 (
        .CLK(CLK), .Rst(Rst), .start(start), .clk_fifo(clk_fifo), .byte_in(byte_in),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .busy(busy0),
        .done(done0), .timeout_err(tmo0), .byte_cnt(cnt0), .checksum(cks0));

    mram_weight_loader #(.NUM_BYTES(N1), .WORD_BYTES(W1), .ADDR_W(10),
                         .SYNC_STAGES(2), .TIMEOUT_CYC(TMO)) dut1 (
        .CLK(CLK), .Rst(Rst), .start(start), .clk_fifo(clk_fifo), .byte_in(byte_in),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .busy(busy1),
        .done(done1), .timeout_err(tmo1), .byte_cnt(cnt1), .checksum(cks1));

    always #5 CLK = ~CLK;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sent_q [$];
    ent_t       got0 [$];
    ent_t       got1 [$];
    ent_t       exp_q [$];
    ent_t       cur_q [$];
    int         last_wr [2];
    int         done_rise [2];
    int         dbl [2];
    bit         done_prev [2];
    bit         wr_prev [2];

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: record every buffer write and the cycle done rises.
    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en_v[d]) begin
                if (d == 0) got0.push_back({wr_addr_v[0], wr_data_v[0]});
                else        got1.push_back({wr_addr_v[1], wr_data_v[1]});
                last_wr[d] = cyc;
                if (wr_prev[d]) dbl[d]++;
            end
            if (done_v[d] && !done_prev[d]) done_rise[d] = cyc;
            done_prev[d] = done_v[d];
            wr_prev[d]   = wr_en_v[d];
        end
    end

    function automatic int wb(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic int nb(input int d);
        return (d == 0) ? N0 : N1;
    endfunction

    function automatic int accepted(input int d);
        return (sent_q.size() < nb(d)) ? sent_q.size() : nb(d);
    endfunction

    function automatic logic [15:0] model_sum(input int d);
        int s = 0;
        for (int i = 0; i < accepted(d); i++) s += int'(sent_q[i]);
        return 16'(s);
    endfunction

    // Reference: words built from the accepted byte list; a completed load
    // zero-pads the last partial word, an aborted one drops it.
    task automatic model_writes(input int d, input bit complete);
        int         w, cnt, nw, idx;
        logic [31:0] data;
        w   = wb(d);
        cnt = accepted(d);
        nw  = complete ? (cnt + w - 1) / w : cnt / w;
        exp_q = {};
        for (int i = 0; i < nw; i++) begin
            data = 32'd0;
            for (int k = 0; k < w; k++) begin
                idx = i * w + k;
                if (idx < cnt) data = data | (32'(sent_q[idx]) << (8 * k));
            end
            exp_q.push_back({10'(i), data});
        end
    endtask

    task automatic fetch_got(input int d);
        if (d == 0) cur_q = got0;
        else        cur_q = got1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        byte_in  = b;
        clk_fifo = 1'b0;
        repeat ($urandom_range(9, 6)) @(negedge CLK);
        clk_fifo = 1'b1;
        byte_in  = 8'($urandom);
        repeat ($urandom_range(9, 6)) @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic start_load();
        got0 = {};
        got1 = {};
        sent_q = {};
        for (int d = 0; d < 2; d++) begin
            last_wr[d]   = -1;
            done_rise[d] = -1;
            dbl[d]       = 0;
        end
        pulse_start();
    endtask

    task automatic test_reset();
        Rst = 1'b1; start = 1'b0; clk_fifo = 1'b1; byte_in = 8'd0;
        repeat (3) @(negedge CLK);
        Rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({wr_en_v[d], busy_v[d], done_v[d], tmo_v[d], wr_addr_v[d],
                 wr_data_v[d], cnt_v[d], cks_v[d]} !== 78'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: cnt=%h cks=%h busy=%b done=%b wr_en=%b, all must be 0",
                         d, cnt_v[d], cks_v[d], busy_v[d], done_v[d], wr_en_v[d]);
            end
        end
    endtask

    task automatic test_idle_strobes();
        got0 = {};
        got1 = {};
        repeat (3) send_byte(8'($urandom));
        for (int d = 0; d < 2; d++) begin
            fetch_got(d);
            checks++;
            if (cur_q.size() != 0 || cnt_v[d] !== 16'd0 || busy_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle_strobes dut%0d: writes=%0d cnt=%0d busy=%b, required 0 0 0",
                         d, cur_q.size(), cnt_v[d], busy_v[d]);
            end
        end
    endtask

    task automatic test_full_load(input bit all_ff, input string tag);
        logic [7:0] b;
        start_load();
        for (int i = 0; i < N0; i++) begin
            if (i == 100) pulse_start();   // ignored while loading
            b = all_ff ? 8'hFF : 8'($urandom);
            sent_q.push_back(b);
            send_byte(b);
        end
        repeat (2) send_byte(8'($urandom)); // strobes in DONE are ignored
        repeat (5) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            model_writes(d, 1'b1);
            fetch_got(d);
            checks++;
            if (cur_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL %s write_count dut%0d: got %0d required %0d", tag, d, cur_q.size(), exp_q.size());
            end
            for (int i = 0; i < cur_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (cur_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d] dut%0d: got addr=%0d data=%h required addr=%0d data=%h",
                             tag, i, d, cur_q[i][41:32], cur_q[i][31:0], exp_q[i][41:32], exp_q[i][31:0]);
                end
            end
            checks++;
            if (cnt_v[d] !== 16'(nb(d))) begin
                errors++;
                $display("FAIL %s byte_cnt dut%0d: got %0d required %0d", tag, d, cnt_v[d], nb(d));
            end
            checks++;
            if (cks_v[d] !== model_sum(d)) begin
                errors++;
                $display("FAIL %s checksum dut%0d: got %h required %h", tag, d, cks_v[d], model_sum(d));
            end
            checks++;
            if (done_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || tmo_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s end_flags dut%0d: done=%b busy=%b timeout=%b required 1 0 0",
                         tag, d, done_v[d], busy_v[d], tmo_v[d]);
            end
            checks++;
            if (done_rise[d] != last_wr[d] + 1 || dbl[d] != 0) begin
                errors++;
                $display("FAIL %s done_timing dut%0d: done at %0d last write at %0d long pulses %0d, required done one cycle after write and 0",
                         tag, d, done_rise[d], last_wr[d], dbl[d]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        int         t;
        start_load();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            sent_q.push_back(b);
            send_byte(b);
        end
        repeat (30) @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tmo_v[d] !== 1'b0 || busy_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL early_timeout dut%0d: timeout=%b busy=%b required 0 1", d, tmo_v[d], busy_v[d]);
            end
        end
        t = 0;
        while (tmo_v !== 2'b11 && t < 150) begin
            @(negedge CLK);
            t++;
        end
        for (int d = 0; d < 2; d++) begin
            model_writes(d, 1'b0);
            fetch_got(d);
            checks++;
            if (tmo_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL timeout_flags dut%0d: timeout=%b busy=%b done=%b required 1 0 0",
                         d, tmo_v[d], busy_v[d], done_v[d]);
            end
            checks++;
            if (cur_q.size() != exp_q.size() || (exp_q.size() > 0 && cur_q.size() > 0 && cur_q[0] !== exp_q[0])) begin
                errors++;
                $display("FAIL timeout_writes dut%0d: got %0d writes required %0d", d, cur_q.size(), exp_q.size());
            end
            checks++;
            if (cnt_v[d] !== 16'd3 || cks_v[d] !== model_sum(d)) begin
                errors++;
                $display("FAIL timeout_counters dut%0d: cnt=%0d cks=%h required 3 %h", d, cnt_v[d], cks_v[d], model_sum(d));
            end
        end
        pulse_start();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (tmo_v[d] !== 1'b0 || busy_v[d] !== 1'b1 || cnt_v[d] !== 16'd0) begin
                errors++;
                $display("FAIL timeout_clear dut%0d: timeout=%b busy=%b cnt=%0d required 0 1 0",
                         d, tmo_v[d], busy_v[d], cnt_v[d]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int n0, n1;
        start_load();
        for (int i = 0; i < 150; i++) begin
            sent_q.push_back(8'($urandom));
            send_byte(sent_q[i]);
        end
        @(negedge CLK);
        Rst = 1'b1;
        @(negedge CLK);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({wr_en_v[d], busy_v[d], done_v[d], tmo_v[d], wr_addr_v[d],
                 wr_data_v[d], cnt_v[d], cks_v[d]} !== 78'd0) begin
                errors++;
                $display("FAIL midload_reset dut%0d: cnt=%h cks=%h addr=%0d busy=%b, all must be 0",
                         d, cnt_v[d], cks_v[d], wr_addr_v[d], busy_v[d]);
            end
        end
        Rst = 1'b0;
        n0 = got0.size();
        n1 = got1.size();
        repeat (5) send_byte(8'($urandom));
        checks++;
        if (got0.size() != n0 || got1.size() != n1 || cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_quiet: writes %0d/%0d cnt %0d/%0d, required %0d/%0d 0/0",
                     got0.size(), got1.size(), cnt0, cnt1, n0, n1);
        end
        test_full_load(1'b0, "reload");
    endtask

    initial begin
        test_reset();
        test_idle_strobes();
        test_full_load(1'b0, "random_load");
        test_full_load(1'b1, "checksum_wrap");
        test_timeout();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
